// File: rtl/riscv_tag_prop_ex_if.sv
// ---------------------------------------------------------------------------
// riscv_tag_prop_ex_if
// Bundle of the ID-side, WB-side and profiling signals for the EX-stage tag
// propagation block. The pipeline, or the bench, drives the master modport.
// The tag block connects to the slave modport.
//
//   ID side : enable_i, flush_i, id_valid_i, id_ready_o, alu_operator_mode_i,
//             rs1_tag_i, rs2_tag_i, use_rs2_i, rd_old_tag_i, multicycle_i
//   EX side : ex_ready_i, busy_o
//   WB side : wb_ready_i, tag_valid_o, tag_result_o
//   Profile : cnt_clr_i, stall_cnt_o
// ---------------------------------------------------------------------------
interface riscv_tag_prop_ex_if #(
  parameter int TAG_WIDTH      = 1,
  parameter int ALU_MODE_WIDTH = 2,
  parameter int CNT_WIDTH      = 16
);
  logic                      enable_i;
  logic                      flush_i;
  logic                      id_valid_i;
  logic                      id_ready_o;
  logic [ALU_MODE_WIDTH-1:0] alu_operator_mode_i;
  logic [TAG_WIDTH-1:0]      rs1_tag_i;
  logic [TAG_WIDTH-1:0]      rs2_tag_i;
  logic                      use_rs2_i;
  logic [TAG_WIDTH-1:0]      rd_old_tag_i;
  logic                      multicycle_i;
  logic                      ex_ready_i;
  logic                      wb_ready_i;
  logic                      tag_valid_o;
  logic [TAG_WIDTH-1:0]      tag_result_o;
  logic                      busy_o;
  logic                      cnt_clr_i;
  logic [CNT_WIDTH-1:0]      stall_cnt_o;

  modport master (
    output enable_i, flush_i, id_valid_i, alu_operator_mode_i, rs1_tag_i,
           rs2_tag_i, use_rs2_i, rd_old_tag_i, multicycle_i, ex_ready_i,
           wb_ready_i, cnt_clr_i,
    input  id_ready_o, tag_valid_o, tag_result_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  enable_i, flush_i, id_valid_i, alu_operator_mode_i, rs1_tag_i,
           rs2_tag_i, use_rs2_i, rd_old_tag_i, multicycle_i, ex_ready_i,
           wb_ready_i, cnt_clr_i,
    output id_ready_o, tag_valid_o, tag_result_o, busy_o, stall_cnt_o
  );
endinterface

// File: rtl/riscv_tag_prop_ex.sv
// ---------------------------------------------------------------------------
// riscv_tag_prop_ex
// EX-stage DIFT tag propagation. The block takes the tag mode that ID decoded
// for an instruction and applies it to the operand tags. The resulting rd tag
// is registered. For MUL/DIV, the block waits for the multicycle unit to
// finish, so the tag reaches WB together with its data. The result is held
// until WB accepts it. A saturating counter records the number of cycles
// spent waiting on multicycle operations.
//
// Ports:
//   clk  - core clock
//   rst  - asynchronous, active-high reset
//   bus  - riscv_tag_prop_ex_if.slave. It carries the ID handshake and
//          operands, the EX completion, the WB handshake and result, and the
//          stall counter.
// ---------------------------------------------------------------------------
module riscv_tag_prop_ex #(
  parameter int TAG_WIDTH      = 1,
  parameter int ALU_MODE_WIDTH = 2,
  parameter int CNT_WIDTH      = 16
) (
  input logic                  clk,
  input logic                  rst,
  riscv_tag_prop_ex_if.slave   bus
);

  localparam logic [ALU_MODE_WIDTH-1:0] MODE_OLD   = ALU_MODE_WIDTH'(0);
  localparam logic [ALU_MODE_WIDTH-1:0] MODE_AND   = ALU_MODE_WIDTH'(1);
  localparam logic [ALU_MODE_WIDTH-1:0] MODE_OR    = ALU_MODE_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX    = '1;

  // IDLE: empty. WAIT: multicycle op in flight. HOLD: result offered to WB.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [TAG_WIDTH-1:0]      result_q, result_d;
  logic [CNT_WIDTH-1:0]      cnt_q;
  logic [ALU_MODE_WIDTH-1:0] eff_mode;
  logic                      ready;
  logic                      accept;

  // HOLD can take a new instruction in the cycle WB drains the current one.
  // This allows back-to-back issue without a bubble.
  assign ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && bus.wb_ready_i);
  assign accept = bus.id_valid_i && ready;

  // Disabling propagation degrades every instruction to "keep rd's old tag".
  assign eff_mode = bus.enable_i ? bus.alu_operator_mode_i : MODE_OLD;

  // Tag function. Every operation is a per-bit logic operation on the tags.
  // An immediate operand counts as untainted: it is neutral for OR and
  // all-ones (identity) for AND.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first.
    // Otherwise, a path that misses an assignment infers a latch.
    result_d = '0;
    case (eff_mode)
      MODE_OLD: result_d = bus.rd_old_tag_i;
      MODE_AND: result_d = bus.rs1_tag_i & (bus.use_rs2_i ? bus.rs2_tag_i : {TAG_WIDTH{1'b1}});
      MODE_OR:  result_d = bus.rs1_tag_i | (bus.use_rs2_i ? bus.rs2_tag_i : {TAG_WIDTH{1'b0}});
      default:  result_d = '0; // CLEAR
    endcase
  end

  // Next-state logic. Flush overrides everything, including an accept in
  // the same cycle.
  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) state_d = bus.multicycle_i ? S_WAIT : S_HOLD;
        end
        S_WAIT: begin
          if (bus.ex_ready_i) state_d = S_HOLD;
        end
        S_HOLD: begin
          if (bus.wb_ready_i) begin
            if (accept) state_d = bus.multicycle_i ? S_WAIT : S_HOLD;
            else        state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All
  // registers then update from the values they held before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The result is captured at accept, which freezes enable_i and the
  // operands. Flush leaves the last value in place; only valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else if (accept && !bus.flush_i) begin
      result_q <= result_d;
    end
  end

  // Counts WAIT cycles. Clear wins over increment, and the count saturates
  // at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr_i) begin
      cnt_q <= '0;
    end else if ((state_q == S_WAIT) && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.id_ready_o   = ready;
  assign bus.tag_valid_o  = (state_q == S_HOLD);
  assign bus.busy_o       = (state_q == S_WAIT);
  assign bus.tag_result_o = result_q;
  assign bus.stall_cnt_o  = cnt_q;

endmodule

// File: tb/tb_riscv_tag_prop_ex.sv
// ---------------------------------------------------------------------------
// tb_riscv_tag_prop_ex
// Self-checking bench for riscv_tag_prop_ex. It runs directed vectors for the
// tag function, hand-written multicycle, back-to-back, flush and counter
// sequences, and randomized traffic compared against a transaction-level
// model. A second instance with a 4-bit counter exercises saturation.
// ---------------------------------------------------------------------------
module tb_riscv_tag_prop_ex;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_tag_prop_ex_if #(.TAG_WIDTH(1), .ALU_MODE_WIDTH(2), .CNT_WIDTH(16)) bus ();
  riscv_tag_prop_ex_if #(.TAG_WIDTH(1), .ALU_MODE_WIDTH(2), .CNT_WIDTH(4))  sbus ();

  riscv_tag_prop_ex #(.TAG_WIDTH(1), .ALU_MODE_WIDTH(2), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  riscv_tag_prop_ex #(.TAG_WIDTH(1), .ALU_MODE_WIDTH(2), .CNT_WIDTH(4)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock. Inputs are driven and outputs sampled 1 time unit after the
  // rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enable_i = 1'b1; bus.flush_i = 1'b0; bus.id_valid_i = 1'b0;
    bus.alu_operator_mode_i = 2'd0; bus.rs1_tag_i = 1'b0; bus.rs2_tag_i = 1'b0;
    bus.use_rs2_i = 1'b0; bus.rd_old_tag_i = 1'b0; bus.multicycle_i = 1'b0;
    bus.ex_ready_i = 1'b0; bus.wb_ready_i = 1'b0; bus.cnt_clr_i = 1'b0;
  endtask

  task automatic drive_instr(input bit en, input bit [1:0] mode, input bit rs1,
                             input bit rs2, input bit use2, input bit old, input bit mc);
    bus.enable_i = en; bus.alu_operator_mode_i = mode; bus.rs1_tag_i = rs1;
    bus.rs2_tag_i = rs2; bus.use_rs2_i = use2; bus.rd_old_tag_i = old;
    bus.multicycle_i = mc; bus.id_valid_i = 1'b1;
  endtask

  // Reference tag function. It uses the rule text directly, with a 1-bit tag.
  function automatic int ref_tag(bit en, int mode, int rs1, int rs2, bit use2, int old);
    int m;
    m = en ? mode : 0;
    if (m == 0) return old;
    if (m == 1) return rs1 & (use2 ? rs2 : 1);
    if (m == 2) return rs1 | (use2 ? rs2 : 0);
    return 0;
  endfunction

  typedef struct {
    bit       en;
    bit [1:0] mode;
    bit       rs1, rs2, use2, old;
    bit       exp;
  } vec_t;

  vec_t vecs[10];

  // Transaction-level model: an instruction is either in flight in the
  // multicycle unit or being offered to WB.
  bit m_in_flight, m_holding;
  int m_result, m_cnt;

  initial begin
    idle_inputs();
    sbus.enable_i = 1'b1; sbus.flush_i = 1'b0; sbus.id_valid_i = 1'b0;
    sbus.alu_operator_mode_i = 2'd0; sbus.rs1_tag_i = 1'b0; sbus.rs2_tag_i = 1'b0;
    sbus.use_rs2_i = 1'b0; sbus.rd_old_tag_i = 1'b0; sbus.multicycle_i = 1'b0;
    sbus.ex_ready_i = 1'b0; sbus.wb_ready_i = 1'b0; sbus.cnt_clr_i = 1'b0;

    //                 en mode  rs1 rs2 use old exp
    vecs[0] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // AND with rs2 -> 0
    vecs[1] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // AND immediate -> 1
    vecs[2] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}; // CLEAR, rd_old=1 -> 0
    vecs[3] = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}; // OR 1|0 -> 1
    vecs[4] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}; // OR immediate ignores rs2
    vecs[5] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // OLD -> rd_old
    vecs[6] = '{1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // disabled OR -> OLD
    vecs[7] = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}; // AND 1&1
    vecs[8] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; // OR 0|1
    vecs[9] = '{1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}; // disabled CLEAR -> OLD

    // ---------------- reset state ----------------
    step();
    check("rst_valid", bus.tag_valid_o, 0);
    check("rst_result", bus.tag_result_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_cnt", bus.stall_cnt_o, 0);
    rst = 1'b0;
    step();
    check("rst_ready_after", bus.id_ready_o, 1);

    // ---------------- table-driven single-cycle accepts ----------------
    foreach (vecs[i]) begin
      drive_instr(vecs[i].en, vecs[i].mode, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].use2, vecs[i].old, 1'b0);
      bus.wb_ready_i = 1'b1;
      step();
      bus.id_valid_i = 1'b0;
      bus.enable_i = ~bus.enable_i; // must not alter the captured result
      check($sformatf("vec%0d_valid", i), bus.tag_valid_o, 1);
      check($sformatf("vec%0d_result", i), bus.tag_result_o, vecs[i].exp);
      step();
      check($sformatf("vec%0d_drain", i), bus.tag_valid_o, 0);
      idle_inputs();
    end

    // ---------------- multicycle OR with 3 stall cycles ----------------
    bus.cnt_clr_i = 1'b1; step(); bus.cnt_clr_i = 1'b0;
    drive_instr(1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("mc_busy%0d", c), bus.busy_o, 1);
      check($sformatf("mc_ready%0d", c), bus.id_ready_o, 0);
      check($sformatf("mc_valid%0d", c), bus.tag_valid_o, 0);
      step();
    end
    check("mc_busy3", bus.busy_o, 1);
    check("mc_ready3", bus.id_ready_o, 0);
    bus.ex_ready_i = 1'b1;
    step();
    bus.ex_ready_i = 1'b0;
    check("mc_done_valid", bus.tag_valid_o, 1);
    check("mc_done_busy", bus.busy_o, 0);
    check("mc_cnt", bus.stall_cnt_o, 4);
    check("mc_result", bus.tag_result_o, 1);
    bus.wb_ready_i = 1'b1; step(); idle_inputs();
    check("mc_drain", bus.tag_valid_o, 0);

    // ---------------- back-to-back with WB backpressure ----------------
    drive_instr(1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // A: OR 1|0
    step();
    drive_instr(1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); // B: CLEAR
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("b2b_ready%0d", c), bus.id_ready_o, 0);
      check($sformatf("b2b_hold_valid%0d", c), bus.tag_valid_o, 1);
      check($sformatf("b2b_hold_result%0d", c), bus.tag_result_o, 1);
      step();
    end
    bus.wb_ready_i = 1'b1;
    #1;
    check("b2b_ready_hs", bus.id_ready_o, 1);
    step();
    bus.id_valid_i = 1'b0;
    check("b2b_B_valid", bus.tag_valid_o, 1);
    check("b2b_B_result", bus.tag_result_o, 0);
    step(); idle_inputs();
    check("b2b_drain", bus.tag_valid_o, 0);

    // ---------------- flush in HOLD with a simultaneous accept ----------------
    drive_instr(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // OR -> 1
    step();
    check("fl_hold_valid", bus.tag_valid_o, 1);
    drive_instr(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // CLEAR, must be dropped
    bus.wb_ready_i = 1'b1;
    bus.flush_i = 1'b1;
    step();
    idle_inputs();
    check("fl_valid", bus.tag_valid_o, 0);
    check("fl_busy", bus.busy_o, 0);
    check("fl_result_kept", bus.tag_result_o, 1);
    step();
    check("fl_still_idle", bus.tag_valid_o, 0);

    // ---------------- clear beats increment in WAIT ----------------
    drive_instr(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(); idle_inputs();
    step(); step();
    check("clr_pre", bus.stall_cnt_o, 6);
    bus.cnt_clr_i = 1'b1; step(); bus.cnt_clr_i = 1'b0;
    check("clr_zero", bus.stall_cnt_o, 0);
    check("clr_still_busy", bus.busy_o, 1);
    step();
    check("clr_resume", bus.stall_cnt_o, 1);
    bus.flush_i = 1'b1; step(); bus.flush_i = 1'b0;
    check("clr_flush_busy", bus.busy_o, 0);
    check("clr_flush_cnt_kept", bus.stall_cnt_o, 2);

    // ---------------- asynchronous reset mid-WAIT ----------------
    bus.cnt_clr_i = 1'b1; step(); bus.cnt_clr_i = 1'b0;
    drive_instr(1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(); idle_inputs();
    for (int c = 0; c < 5; c++) step();
    check("ar_cnt5", bus.stall_cnt_o, 5);
    rst = 1'b1;
    #1;
    check("ar_valid", bus.tag_valid_o, 0);
    check("ar_busy", bus.busy_o, 0);
    check("ar_cnt", bus.stall_cnt_o, 0);
    #2;
    rst = 1'b0;
    step();
    check("ar_ready", bus.id_ready_o, 1);

    // ---------------- randomized traffic against the model ----------------
    m_in_flight = 1'b0; m_holding = 1'b0; m_result = 0; m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      bit rv, rmc, rex, rwb, rfl, rclr, ren, ruse, r1, r2, rold, mready, macc;
      int rmode;
      rv = ($urandom_range(0, 1) == 1); rmc = ($urandom_range(0, 2) == 0);
      rex = ($urandom_range(0, 2) == 0); rwb = ($urandom_range(0, 4) < 3);
      rfl = ($urandom_range(0, 24) == 0); rclr = ($urandom_range(0, 39) == 0);
      ren = ($urandom_range(0, 4) != 0); ruse = $urandom_range(0, 1) == 1;
      r1 = $urandom_range(0, 1) == 1; r2 = $urandom_range(0, 1) == 1;
      rold = $urandom_range(0, 1) == 1; rmode = $urandom_range(0, 3);

      bus.id_valid_i = rv; bus.multicycle_i = rmc; bus.ex_ready_i = rex;
      bus.wb_ready_i = rwb; bus.flush_i = rfl; bus.cnt_clr_i = rclr;
      bus.enable_i = ren; bus.use_rs2_i = ruse; bus.rs1_tag_i = r1;
      bus.rs2_tag_i = r2; bus.rd_old_tag_i = rold; bus.alu_operator_mode_i = 2'(rmode);

      mready = !m_in_flight && (!m_holding || rwb);
      macc = rv && mready;
      #1;
      check("rnd_ready", bus.id_ready_o, mready);

      if (rclr) m_cnt = 0;
      else if (m_in_flight && m_cnt < 65535) m_cnt++;
      if (rfl) begin
        m_in_flight = 1'b0;
        m_holding = 1'b0;
      end else begin
        if (m_in_flight && rex) begin
          m_in_flight = 1'b0;
          m_holding = 1'b1;
        end else if (m_holding && rwb) begin
          m_holding = 1'b0;
        end
        if (macc) begin
          m_result = ref_tag(ren, rmode, r1, r2, ruse, rold);
          if (rmc) m_in_flight = 1'b1;
          else     m_holding = 1'b1;
        end
      end

      step();
      check("rnd_valid", bus.tag_valid_o, m_holding);
      check("rnd_busy", bus.busy_o, m_in_flight);
      check("rnd_result", bus.tag_result_o, m_result);
      check("rnd_cnt", bus.stall_cnt_o, m_cnt);
    end
    idle_inputs();

    // ---------------- saturation on the 4-bit counter instance ----------------
    sbus.cnt_clr_i = 1'b1; step(); sbus.cnt_clr_i = 1'b0;
    sbus.multicycle_i = 1'b1; sbus.id_valid_i = 1'b1;
    step();
    sbus.id_valid_i = 1'b0; sbus.multicycle_i = 1'b0;
    for (int c = 0; c < 14; c++) step();
    check("sat_pre", sbus.stall_cnt_o, 14);
    for (int c = 0; c < 3; c++) step();
    check("sat_max", sbus.stall_cnt_o, 15);
    check("sat_busy", sbus.busy_o, 1);
    sbus.cnt_clr_i = 1'b1; step(); sbus.cnt_clr_i = 1'b0;
    check("sat_clr", sbus.stall_cnt_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_tag_prop_ex.md
Name: riscv_tag_prop_ex

Overview:
- EX-stage consumer of the per-instruction tag mode generated in ID; applies that mode to operand tags and produces the destination-register tag for write-back.
- Registers the result and tracks multicycle EX operations (MUL/DIV) so the tag leaves EX together with its data.
- Holds the result until WB accepts it and keeps a saturating count of multicycle stall cycles for DIFT profiling.

Parameters:
TAG_WIDTH, 1, tag bits per register
ALU_MODE_WIDTH, 2, width of the mode field; encodings are OLD=2'b00, AND=2'b01, OR=2'b10, CLEAR=2'b11
CNT_WIDTH, 16, width of the stall counter

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
enable_i  in  1  tag propagation enable; 0 forces mode OLD
flush_i  in  1  synchronous pipeline flush
id_valid_i  in  1  ID presents an instruction to EX
id_ready_o  out  1  block can accept an instruction
alu_operator_mode_i  in  ALU_MODE_WIDTH  tag mode for the instruction
rs1_tag_i  in  TAG_WIDTH  rs1 operand tag
rs2_tag_i  in  TAG_WIDTH  rs2 operand tag
use_rs2_i  in  1  second operand is rs2 (0 = immediate)
rd_old_tag_i  in  TAG_WIDTH  current tag of rd
multicycle_i  in  1  instruction is MUL/DIV (multicycle)
ex_ready_i  in  1  multicycle EX unit finished
wb_ready_i  in  1  WB accepts the tag
tag_valid_o  out  1  tag_result_o is valid
tag_result_o  out  TAG_WIDTH  computed rd tag
busy_o  out  1  state is WAIT
cnt_clr_i  in  1  clear the stall counter
stall_cnt_o  out  CNT_WIDTH  saturating count of WAIT cycles

Behaviour:
- Reset (asynchronous, rst=1):
  - state IDLE; tag_valid_o=0, tag_result_o=0, busy_o=0, stall_cnt_o=0.
  - id_ready_o=1 one cycle after release.
- Result function, evaluated at accept:
  - Effective mode = enable_i ? alu_operator_mode_i : OLD.
  - OLD -> rd_old_tag_i.
  - AND -> rs1_tag_i & (use_rs2_i ? rs2_tag_i : all-ones).
  - OR -> rs1_tag_i | (use_rs2_i ? rs2_tag_i : 0).
  - CLEAR -> 0.
  - The result is captured into the output register on accept.
- Accept happens when id_valid_i & id_ready_o.
  - id_ready_o = (state==IDLE) | (state==HOLD & wb_ready_i).
  - id_ready_o is 0 in WAIT.
- States:
  - IDLE:
    - accept with multicycle_i=0 -> HOLD; tag_valid_o=1 next cycle (1-cycle latency).
    - accept with multicycle_i=1 -> WAIT; tag_valid_o stays 0.
  - WAIT:
    - busy_o=1; stall_cnt_o increments each cycle.
    - ex_ready_i=1 -> HOLD; tag_valid_o=1 next cycle.
    - ex_ready_i is ignored outside WAIT.
  - HOLD:
    - tag_valid_o=1; tag_result_o is stable.
    - wb_ready_i=1 with no accept -> IDLE.
    - wb_ready_i=1 with a simultaneous accept -> the new instruction follows the IDLE rules in the same cycle (back-to-back, no bubble).
    - wb_ready_i=0 -> stay in HOLD, inputs ignored.
- flush_i:
  - Highest priority over all transitions: state -> IDLE next cycle, tag_valid_o=0, busy_o=0.
  - An accept in the flush cycle is discarded.
  - tag_result_o keeps its value; the counter is preserved.
- Stall counter:
  - cnt_clr_i has priority over increment; clr=1 sets the count to 0 next cycle.
  - Saturates at 2^CNT_WIDTH-1; it never wraps.
- Width rules: all tag operations are bitwise per bit of TAG_WIDTH; no arithmetic on tags.
- enable_i is sampled only at accept; changing it in WAIT or HOLD does not alter the captured result.

Test Plan:
- Reset asserted mid-WAIT (stall_cnt_o=5) -> same cycle: tag_valid_o=0, busy_o=0, stall_cnt_o=0; after release, id_ready_o=1.
- Mode AND, rs1=1, rs2=0, use_rs2=1, wb_ready=1 -> tag_result_o=0, tag_valid_o=1 one cycle later. Same with use_rs2=0 -> tag_result_o=1. Mode CLEAR, rd_old=1 -> tag_result_o=0.
- Mode OR, multicycle_i=1, ex_ready_i low for 3 cycles then high -> busy_o=1 for 4 cycles, stall_cnt_o=4, tag_valid_o=1 the cycle after ex_ready_i, id_ready_o=0 throughout WAIT.
- Back-to-back single-cycle instructions A (OR, 1|0) and B (CLEAR) with wb_ready held 0 for 2 cycles then 1 -> A's tag 1 held stable in HOLD, id_ready_o=0; B is accepted on the WB handshake cycle; next cycle tag_result_o=0.
- enable_i=0, mode OR, rs1=1, rd_old=0 -> tag_result_o=0 (OLD). flush_i in HOLD together with id_valid_i -> next cycle IDLE, tag_valid_o=0, instruction dropped.
- Counter forced to 16'hFFFE, 3 WAIT cycles -> 16'hFFFF, no wrap. cnt_clr_i in a WAIT cycle -> 0 next cycle (clr beats increment).
